// File: rtl/bcd_conv_sched.sv
// Time-shares one combinational binary-to-BCD converter across seconds, minutes and hours,
// then publishes all six digits and range flags together with a one-cycle done pulse.
module bcd_conv_sched #(
    parameter int unsigned LIM_SEC = 60,
    parameter int unsigned LIM_MIN = 60,
    parameter int unsigned LIM_HR  = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  val_sec,
    input  logic [5:0]  val_min,
    input  logic [5:0]  val_hr,
    output logic [5:0]  conv_bin,
    input  logic [3:0]  conv_unid,
    input  logic [3:0]  conv_dec,
    output logic [23:0] digits,
    output logic [2:0]  err,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {StIdle, StSample, StCommit} state_t;

    state_t      state_q, state_d;
    logic [1:0]  ch_q, ch_d;
    logic        pend_q, pend_d;
    logic [17:0] snap_q, snap_d;
    logic [23:0] shadow_q, shadow_d;
    logic [2:0]  err_sh_q, err_sh_d;
    logic [5:0]  conv_bin_q, conv_bin_d;
    logic [23:0] digits_q, digits_d;
    logic [2:0]  err_q, err_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [5:0]  field;
    int unsigned lim;
    logic        over;
    logic [7:0]  pair;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            ch_q       <= 2'd0;
            pend_q     <= 1'b0;
            snap_q     <= '0;
            shadow_q   <= '0;
            err_sh_q   <= '0;
            conv_bin_q <= '0;
            digits_q   <= '0;
            err_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            pend_q     <= pend_d;
            snap_q     <= snap_d;
            shadow_q   <= shadow_d;
            err_sh_q   <= err_sh_d;
            conv_bin_q <= conv_bin_d;
            digits_q   <= digits_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Field currently on the converter and its range limit
    always_comb begin
        case (ch_q)
            2'd0: begin field = snap_q[5:0];   lim = LIM_SEC; end
            2'd1: begin field = snap_q[11:6];  lim = LIM_MIN; end
            default: begin field = snap_q[17:12]; lim = LIM_HR; end
        endcase
        over = (32'(field) >= lim);
        pair = {conv_dec, conv_unid};
    end

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        pend_d     = pend_q;
        snap_d     = snap_q;
        shadow_d   = shadow_q;
        err_sh_d   = err_sh_q;
        conv_bin_d = conv_bin_q;
        digits_d   = digits_q;
        err_d      = err_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    snap_d     = {val_hr, val_min, val_sec};
                    conv_bin_d = val_sec;
                    ch_d       = 2'd0;
                    busy_d     = 1'b1;
                    state_d    = StSample;
                end
            end
            StSample: begin
                if (start) pend_d = 1'b1;
                case (ch_q)
                    2'd0: begin
                        shadow_d[7:0] = pair;
                        err_sh_d[0]   = over;
                        conv_bin_d    = snap_q[11:6];
                        ch_d          = 2'd1;
                    end
                    2'd1: begin
                        shadow_d[15:8] = pair;
                        err_sh_d[1]    = over;
                        conv_bin_d     = snap_q[17:12];
                        ch_d           = 2'd2;
                    end
                    default: begin
                        shadow_d[23:16] = pair;
                        err_sh_d[2]     = over;
                        state_d         = StCommit;
                    end
                endcase
            end
            StCommit: begin
                digits_d = shadow_q;
                err_d    = err_sh_q;
                done_d   = 1'b1;
                // A request seen during the sequence (or right now) restarts immediately
                if (pend_q || start) begin
                    snap_d     = {val_hr, val_min, val_sec};
                    conv_bin_d = val_sec;
                    ch_d       = 2'd0;
                    pend_d     = 1'b0;
                    state_d    = StSample;
                end else begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign conv_bin = conv_bin_q;
    assign digits   = digits_q;
    assign err      = err_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Scoreboard bench for bcd_conv_sched: stimulus pushes expected {err, digits}, a monitor
// pops and compares on every done pulse.
module tb_bcd_conv_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  val_sec, val_min, val_hr;
    logic [5:0]  conv_bin;
    logic [3:0]  conv_unid, conv_dec;
    logic [23:0] digits;
    logic [2:0]  err;
    logic        busy, done;

    int total = 0;
    int bad   = 0;
    logic [26:0] exp_q[$];
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    // Shared converter model
    assign conv_unid = 4'(conv_bin % 6'd10);
    assign conv_dec  = 4'(conv_bin / 6'd10);

    bcd_conv_sched dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .val_sec   (val_sec),
        .val_min   (val_min),
        .val_hr    (val_hr),
        .conv_bin  (conv_bin),
        .conv_unid (conv_unid),
        .conv_dec  (conv_dec),
        .digits    (digits),
        .err       (err),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vals(input int s, input int m, input int h);
        val_sec = 6'(s);
        val_min = 6'(m);
        val_hr  = 6'(h);
    endtask

    task automatic push(input logic [23:0] d, input logic [2:0] e);
        exp_q.push_back({e, d});
    endtask

    function automatic logic [7:0] bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    always @(negedge clk) begin
        if (done) begin
            total++;
            if (prev_done) begin
                bad++;
                $display("FAIL done_twice: got done high in consecutive cycles want single pulse");
            end
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: got digits=%h err=%b want no done", digits, err);
            end else begin
                logic [26:0] e;
                e = exp_q.pop_front();
                if ({err, digits} !== e) begin
                    bad++;
                    $display("FAIL publish: got err=%b digits=%h want err=%b digits=%h",
                             err, digits, e[26:24], e[23:0]);
                end
            end
        end
        prev_done = done;
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        set_vals(0, 0, 0);
        tick();
        tick();
        chk("rst_conv_bin", 32'(conv_bin), 0);
        chk("rst_digits", 32'(digits), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        reset = 1'b0;
        tick();

        // Basic sequence
        set_vals(45, 7, 23);
        start = 1'b1;
        push(24'h230745, 3'b000);
        tick();
        start = 1'b0;
        chk("t1_conv_sec", 32'(conv_bin), 45);
        chk("t1_busy", 32'(busy), 1);
        tick();
        chk("t1_conv_min", 32'(conv_bin), 7);
        tick();
        chk("t1_conv_hr", 32'(conv_bin), 23);
        tick();
        tick();
        chk("t1_done", 32'(done), 1);
        chk("t1_busy_low", 32'(busy), 0);
        tick();
        chk("t1_done_low", 32'(done), 0);

        // Range limits
        set_vals(60, 59, 24);
        start = 1'b1;
        push(24'h245960, 3'b101);
        tick();
        start = 1'b0;
        repeat (5) tick();
        set_vals(60, 59, 63);
        start = 1'b1;
        push(24'h635960, 3'b101);
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("t2_hr63", 32'(digits[23:16]), 32'h63);
        chk("t2_err2", 32'(err[2]), 1);
        tick();

        // Snapshot coherence and one-deep pending request
        set_vals(12, 1, 2);
        start = 1'b1;
        push(24'h020112, 3'b000);
        tick();                 // E0
        start = 1'b0;
        tick();                 // E1
        val_sec = 6'd34;
        start = 1'b1;
        push(24'h020134, 3'b000);
        tick();                 // E2
        start = 1'b0;
        for (int e = 3; e <= 7; e++) begin
            tick();
            chk("t3_busy_hold", 32'(busy), 1);
        end
        tick();                 // E8
        chk("t3_done2", 32'(done), 1);
        chk("t3_sec34", 32'(digits[7:0]), 32'h34);
        chk("t3_busy_end", 32'(busy), 0);
        repeat (6) tick();

        // Reset mid-sequence aborts
        set_vals(1, 2, 3);
        start = 1'b1;
        tick();                 // E0
        start = 1'b0;
        tick();                 // E1
        reset = 1'b1;
        tick();                 // E2
        chk("t4_conv_bin", 32'(conv_bin), 0);
        chk("t4_digits", 32'(digits), 0);
        chk("t4_err", 32'(err), 0);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_done", 32'(done), 0);
        reset = 1'b0;
        repeat (4) tick();
        set_vals(5, 10, 11);
        start = 1'b1;
        push(24'h111005, 3'b000);
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("t4_fresh", 32'(digits), 32'h111005);
        chk("t4_fresh_busy", 32'(busy), 0);
        tick();

        // start held continuously for 20 cycles
        for (int i = 0; i < 20; i++) begin
            set_vals(3 * i, 59 - 2 * i, i);
            start = 1'b1;
            if (i % 4 == 0) push({bcd2(i), bcd2(59 - 2 * i), bcd2(3 * i)}, 3'b000);
            tick();
            chk("t5_busy", 32'(busy), 1);
        end
        // Request pending from the last sample window snapshots these at E20
        set_vals(60, 19, 20);
        start = 1'b0;
        push(24'h201960, 3'b001);
        tick();
        chk("t5_done20", 32'(done), 1);
        repeat (4) tick();
        chk("t5_busy_end", 32'(busy), 0);
        repeat (6) tick();

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_conv_sched.md
Name: bcd_conv_sched

Overview:
- Sequencer that shares one combinational 6-bit binary-to-BCD converter (num_bin in; unid and dec out) between three time-field requesters: seconds, minutes and hours.
- On each start request it takes a snapshot of all three fields. It then presents them to the converter one at a time, captures the digit pair returned for each, and publishes all six BCD digits atomically with a done pulse.
- It sits between the timekeeping counters and the 7-segment display driver.

Parameters:
- LIM_SEC, 60, seconds value at or above this sets err[0]
- LIM_MIN, 60, minutes value at or above this sets err[1]
- LIM_HR, 24, hours value at or above this sets err[2]

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  conversion request, sampled each edge
- val_sec  input  6  seconds binary value
- val_min  input  6  minutes binary value
- val_hr  input  6  hours binary value
- conv_bin  output  6  registered drive to the shared converter's num_bin
- conv_unid  input  4  converter units digit, combinational from conv_bin
- conv_dec  input  4  converter tens digit, combinational from conv_bin
- digits  output  24  published BCD digits: [3:0] sec_unid, [7:4] sec_dec, [11:8] min_unid, [15:12] min_dec, [19:16] hr_unid, [23:20] hr_dec
- err  output  3  range flags per field: bit0 sec, bit1 min, bit2 hr; published together with digits
- busy  output  1  high while a conversion sequence is in flight
- done  output  1  one-cycle pulse when digits and err update

Behaviour:
- Reset values:
  - conv_bin = 0, digits = 0, err = 0, busy = 0, done = 0.
  - Internal state: state = IDLE, ch = 0, pend = 0, snapshot = 0, shadow = 0.
  - Reset has priority over all other inputs.
  - Reset mid-sequence aborts the sequence; no publish or done occurs for the aborted request.
- States: IDLE, SAMPLE, COMMIT. ch is a 2-bit index: 0 = sec, 1 = min, 2 = hr.
- IDLE with start = 1 at edge E0:
  - snap <= {val_hr, val_min, val_sec}; conv_bin <= val_sec; ch <= 0; busy <= 1.
  - Next state SAMPLE.
- IDLE with start = 0: all outputs hold; done <= 0.
- SAMPLE:
  - Each edge: shadow[ch] <= {conv_dec, conv_unid}; err_sh[ch] <= (snap[ch] >= LIM[ch]).
  - If ch < 2: ch <= ch + 1 and conv_bin <= snap[ch + 1]; stay in SAMPLE.
  - If ch == 2: go to COMMIT. conv_bin holds its value.
  - Captures occur at edges E1, E2 and E3.
- COMMIT, at edge E4:
  - digits <= shadow; err <= err_sh; done <= 1 for exactly one cycle.
  - If (pend | start) = 1: re-snapshot the current inputs, conv_bin <= val_sec, ch <= 0, pend <= 0, busy stays 1; next state SAMPLE.
  - Otherwise: busy <= 0; next state IDLE.
- Latency: digits valid 4 edges after the start edge; busy is high from after E0 through E4.
- start while busy (SAMPLE state): sets pend. Multiple requests collapse into one; there is no queue deeper than 1.
- Inputs changing during a sequence are ignored; only the snapshot is converted, so all published digits are coherent.
- Converter results are passed through unchanged. Values 60..63 appear as dec = 6, unid = 0..3, with err set per the limits.
- digits and err never change except at COMMIT or reset.
- done is never high in two consecutive cycles. Back-to-back sequences have 4 edges between done pulses.

Test Plan:
- Reset, then sec = 45, min = 7, hr = 23, start at E0:
  - conv_bin = 45, 7, 23 after E0, E1, E2.
  - After E4: digits = 0x230745, err = 000, done high one cycle, busy low.
- sec = 60, min = 59, hr = 24:
  - After E4: digits = 0x245960, err = 101.
  - A follow-up request with hr = 63 gives digits[23:16] = 0x63, err[2] = 1.
- Start at E0, change val_sec 12 -> 34 at E1, start again at E2:
  - First done shows sec 0x12.
  - busy stays 1; second done at E8 shows sec 0x34.
  - No third sequence runs.
- Start at E0, reset high at E2:
  - All outputs 0 after E2, no done pulse.
  - A fresh start then completes normally in 4 edges.
- start held high continuously for 20 cycles:
  - done pulses every 4 cycles, busy stays high.
  - digits track the inputs sampled at each COMMIT edge.
